// File: rtl/mem_ctrl.sv
// Main-memory responder on the snoopy bus: returns a line after a fixed latency
// and absorbs written-back or flushed lines.
module mem_ctrl #(
  parameter int unsigned ADDR_SIZE       = 32,
  parameter int unsigned CACHE_LINE_SIZE = 128,
  parameter int unsigned MEM_LINES       = 16,
  parameter int unsigned MEM_LATENCY     = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       bus_valid_i,
  input  logic [1:0]                 bus_msg_i,
  input  logic [ADDR_SIZE-1:0]       bus_addr_i,
  input  logic                       flush_i,
  input  logic [CACHE_LINE_SIZE-1:0] flush_data_i,
  output logic [CACHE_LINE_SIZE-1:0] data_o,
  output logic                       data_valid_o,
  output logic                       busy_o,
  output logic                       overrun_o
);

  localparam int unsigned OFFSET = $clog2(CACHE_LINE_SIZE / 8);
  localparam int unsigned IDX_W  = $clog2(MEM_LINES);
  localparam int unsigned CNT_W  = 4;
  localparam logic [1:0]  MSG_WB = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                     state;
  state_t                     state_nxt;
  logic [CNT_W-1:0]           cnt;
  logic [CNT_W-1:0]           cnt_nxt;
  logic [IDX_W-1:0]           idx;
  logic [IDX_W-1:0]           cap_idx;
  logic [IDX_W-1:0]           cap_idx_nxt;
  logic [CACHE_LINE_SIZE-1:0] mem [MEM_LINES];
  logic                       rd_start;
  logic                       wr_en;
  logic                       data_valid_nxt;
  logic [CACHE_LINE_SIZE-1:0] data_nxt;
  logic                       unused_addr;

  // Bits above the index alias onto the same line; bits below select bytes.
  assign idx         = bus_addr_i[OFFSET +: IDX_W];
  assign unused_addr = ^bus_addr_i;

  // Only an idle controller accepts a transaction; anything else is an overrun.
  assign rd_start = bus_valid_i && (state == S_IDLE) && !bus_msg_i[1] && !flush_i;
  assign wr_en    = bus_valid_i && (state == S_IDLE) && (flush_i || (bus_msg_i == MSG_WB));
  assign busy_o   = (state != S_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    cap_idx_nxt = cap_idx;
    case (state)
      S_IDLE: begin
        if (rd_start) begin
          cap_idx_nxt = idx;
          cnt_nxt     = CNT_W'(MEM_LATENCY - 1);
          state_nxt   = (MEM_LATENCY > 1) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Fill data is read from the array on the edge entering RESP, so earlier writes are seen.
  always_comb begin
    data_valid_nxt = (state_nxt == S_RESP);
    data_nxt       = '0;
    if (data_valid_nxt) begin
      data_nxt = mem[cap_idx_nxt];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt          <= '0;
      cap_idx      <= '0;
      data_o       <= '0;
      data_valid_o <= 1'b0;
      overrun_o    <= 1'b0;
      for (int i = 0; i < int'(MEM_LINES); i++) begin
        mem[i] <= '0;
      end
    end else begin
      cnt          <= cnt_nxt;
      cap_idx      <= cap_idx_nxt;
      data_o       <= data_nxt;
      data_valid_o <= data_valid_nxt;
      if (bus_valid_i && (state != S_IDLE)) begin
        overrun_o <= 1'b1;
      end
      if (wr_en) begin
        mem[idx] <= flush_data_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: two instances (latency 4 and latency 1) share one bus,
// checked every cycle against a cycle-count model plus directed literal checks.
module tb_mem_ctrl;

  logic         clk;
  logic         rst;
  logic         bus_valid;
  logic [1:0]   bus_msg;
  logic [31:0]  bus_addr;
  logic         flush;
  logic [127:0] flush_data;

  logic [127:0] d_o [2];
  logic         dv  [2];
  logic         bz  [2];
  logic         ov  [2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_sample = 0;
  bit chk_en   = 0;

  mem_ctrl #(.MEM_LATENCY(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .bus_valid_i(bus_valid), .bus_msg_i(bus_msg),
    .bus_addr_i(bus_addr), .flush_i(flush), .flush_data_i(flush_data),
    .data_o(d_o[0]), .data_valid_o(dv[0]), .busy_o(bz[0]), .overrun_o(ov[0])
  );

  mem_ctrl #(.MEM_LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .bus_valid_i(bus_valid), .bus_msg_i(bus_msg),
    .bus_addr_i(bus_addr), .flush_i(flush), .flush_data_i(flush_data),
    .data_o(d_o[1]), .data_valid_o(dv[1]), .busy_o(bz[1]), .overrun_o(ov[1])
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Model: per instance, busy_left counts the busy cycles still to come; the fill
  // is visible in the last of them.
  logic [127:0] mm [2][16];
  int           bl  [2];
  int           pd  [2];
  bit           mo  [2];
  int           lat [2];

  initial begin
    int ix;
    lat[0] = 4;
    lat[1] = 1;
    forever begin
      @(posedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          for (int j = 0; j < 16; j++) mm[k][j] = '0;
          bl[k] = 0;
          pd[k] = 0;
          mo[k] = 0;
        end else if (bl[k] > 0) begin
          if (bus_valid) mo[k] = 1;
          bl[k]--;
        end else if (bus_valid) begin
          ix = int'(bus_addr[7:4]);
          if (bus_msg == 2'b11 || flush) begin
            mm[k][ix] = flush_data;
          end else if (bus_msg < 2'b10) begin
            bl[k] = lat[k];
            pd[k] = ix;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int k = 0; k < 2; k++) begin
          chk($sformatf("dut%0d valid", k), dv[k], (bl[k] == 1));
          chk($sformatf("dut%0d busy", k), bz[k], (bl[k] > 0));
          chk($sformatf("dut%0d overrun", k), ov[k], mo[k]);
          chk($sformatf("dut%0d data", k), d_o[k], (bl[k] == 1) ? mm[k][pd[k]] : 128'h0);
        end
      end
    end
  end

  // Presents one transaction for exactly one sampling edge.
  task automatic txn(input logic [1:0] msg, input logic [31:0] addr, input logic fl,
                     input logic [127:0] fd);
    bus_valid  = 1;
    bus_msg    = msg;
    bus_addr   = addr;
    flush      = fl;
    flush_data = fd;
    @(posedge clk);
    #1;
    bus_valid  = 0;
    flush      = 0;
    last_sample = cyc;
  endtask

  // Waits (bounded) for the latency-4 fill, checks timing and data, then the idle cycle.
  task automatic wait_fill4(input string nm, input int c0, input logic [127:0] exp);
    int guard = 0;
    while (dv[0] !== 1'b1 && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk({nm, " valid"}, dv[0], 1'b1);
    chk({nm, " latency"}, 128'(cyc - c0 + 1), 128'd4);
    chk({nm, " data"}, d_o[0], exp);
    @(posedge clk);
    #1;
    chk({nm, " busy drop"}, bz[0], 1'b0);
    chk({nm, " valid drop"}, dv[0], 1'b0);
  endtask

  logic [127:0] t6 [3];
  int c0;
  int prev;

  initial begin
    t6[0] = 128'h11;
    t6[1] = 128'h22;
    t6[2] = 128'h33;
    rst = 1; bus_valid = 0; bus_msg = 0; bus_addr = 0; flush = 0; flush_data = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    chk_en = 1;
    chk("reset valid", dv[0], 1'b0);
    chk("reset busy", bz[0], 1'b0);
    chk("reset overrun", ov[0], 1'b0);
    chk("reset data", d_o[0], 128'h0);

    // 1: latency from an empty line
    txn(2'b00, 32'h30, 0, 0);
    c0 = last_sample;
    chk("t1 busy", bz[0], 1'b1);
    wait_fill4("t1", c0, 128'h0);

    // 2: write-back then read, plus an aliased address
    txn(2'b11, 32'h20, 0, 128'hDEAD);
    txn(2'b00, 32'h20, 0, 0);
    wait_fill4("t2", last_sample, 128'hDEAD);
    txn(2'b00, 32'h120, 0, 0);
    wait_fill4("t2 alias", last_sample, 128'hDEAD);

    // 3: cache-to-cache transfer
    txn(2'b01, 32'h40, 1, 128'hCAFE);
    chk("t3 no valid", dv[0], 1'b0);
    chk("t3 no busy", bz[0], 1'b0);
    @(posedge clk);
    #1;
    chk("t3 still idle", bz[0], 1'b0);
    txn(2'b00, 32'h40, 0, 0);
    wait_fill4("t3", last_sample, 128'hCAFE);

    // 4: overrun while busy
    txn(2'b00, 32'h50, 0, 0);
    c0 = last_sample;
    @(posedge clk);
    #1;
    txn(2'b00, 32'h60, 1, 128'hBAD);
    chk("t4 overrun", ov[0], 1'b1);
    wait_fill4("t4 first", c0, 128'h0);
    txn(2'b00, 32'h60, 0, 0);
    wait_fill4("t4 unchanged", last_sample, 128'h0);
    chk("t4 overrun sticky", ov[0], 1'b1);

    // 5: reset during WAIT
    txn(2'b00, 32'h20, 0, 0);
    chk("t5 busy", bz[0], 1'b1);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    chk("t5 busy after rst", bz[0], 1'b0);
    chk("t5 overrun after rst", ov[0], 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("t5 no valid", dv[0], 1'b0);
      @(posedge clk);
      #1;
    end
    txn(2'b00, 32'h20, 0, 0);
    wait_fill4("t5 cleared 0x20", last_sample, 128'h0);
    txn(2'b00, 32'h40, 0, 0);
    wait_fill4("t5 cleared 0x40", last_sample, 128'h0);

    // 6: back-to-back reads on the latency-1 instance
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    txn(2'b11, 32'h10, 0, 128'h11);
    txn(2'b11, 32'h20, 0, 128'h22);
    txn(2'b11, 32'h30, 0, 128'h33);
    prev = 0;
    for (int i = 1; i <= 3; i++) begin
      txn(2'b00, 32'(i * 16), 0, 0);
      chk($sformatf("t6 rd%0d valid", i), dv[1], 1'b1);
      chk($sformatf("t6 rd%0d data", i), d_o[1], t6[i-1]);
      if (i > 1) chk($sformatf("t6 rd%0d spacing", i), 128'(last_sample - prev), 128'd2);
      prev = last_sample;
      @(posedge clk);
      #1;
      chk($sformatf("t6 rd%0d idle", i), bz[1], 1'b0);
    end
    chk("t6 overrun", ov[1], 1'b0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Main-memory responder at the far end of the MSI snoopy bus.
- Samples each granted bus transaction (message, address, flush). It returns a line after a fixed latency, or absorbs flushed/written-back data when a cache supplies the line instead.
- Gives the bus arbiter a busy indication so no new grant is issued while a fill is outstanding.

Parameters:
- ADDR_SIZE, 32, bus address width.
- CACHE_LINE_SIZE, 128, line width in bits.
- MEM_LINES, 16, number of lines held. Power of two, >=2.
- MEM_LATENCY, 4, cycles from transaction sample to data_valid_o. Range 1..15.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- bus_valid_i  in  1  a granted transaction is on the bus this cycle.
- bus_msg_i  in  2  00 BusRd, 01 BusRdX, 10 BusUpgr, 11 WriteBack.
- bus_addr_i  in  ADDR_SIZE  transaction address.
- flush_i  in  1  owner/snooper is driving line data this cycle.
- flush_data_i  in  CACHE_LINE_SIZE  flushed or written-back line.
- data_o  out  CACHE_LINE_SIZE  fill data; 0 when data_valid_o=0.
- data_valid_o  out  1  one-cycle fill strobe.
- busy_o  out  1  fill outstanding; arbiter must not grant.
- overrun_o  out  1  sticky; a transaction arrived while busy.

Behaviour:
- Addressing:
  - OFFSET = log2(CACHE_LINE_SIZE/8), which is 4 at the default line width.
  - index = bus_addr_i[OFFSET +: log2(MEM_LINES)].
  - Upper bits are ignored, so aliasing is allowed.
- Storage: MEM_LINES x CACHE_LINE_SIZE registers. All lines are cleared to 0 on reset.
- Reset values: data_o=0, data_valid_o=0, busy_o=0, overrun_o=0, state=IDLE, latency counter=0, captured index=0.
- FSM states: IDLE, WAIT, RESP.
- IDLE, on bus_valid_i=1, acts on the rising edge that samples it:
  - BusRd/BusRdX with flush_i=0: capture index; counter <= MEM_LATENCY-1; next state is WAIT if MEM_LATENCY>1, else RESP.
  - BusRd/BusRdX with flush_i=1: this is a cache-to-cache transfer. mem[index] <= flush_data_i. There is no fill and the state stays IDLE.
  - BusUpgr: no data and no state change. If flush_i=1 in the same cycle, mem[index] <= flush_data_i.
  - WriteBack: mem[index] <= flush_data_i regardless of flush_i. State stays IDLE.
- WAIT:
  - The counter decrements each cycle.
  - When counter==1, next state is RESP.
- RESP:
  - data_valid_o=1 and data_o=mem[captured index] for exactly one cycle.
  - Next state is IDLE.
- busy_o is high in WAIT and RESP, and is combinational from state.
- Latency: a read sampled at edge T gives data_valid_o high in the cycle following edge T+MEM_LATENCY-1. That is, it is visible exactly MEM_LATENCY cycles after the sampling cycle.
- Back-to-back transactions: a new read may be sampled in the first IDLE cycle after RESP. Zero idle gap is required.
- bus_valid_i=1 while busy_o=1 (protocol violation):
  - The transaction is dropped. No memory write occurs, even with flush_i.
  - overrun_o is set and held until reset.
  - The in-flight fill completes unaffected.
- flush_i=1 with bus_valid_i=0: ignored, since flush data is only meaningful inside a granted transaction.
- Read-after-write: a WriteBack or flush sampled at edge T is visible to a read sampled at edge T+1 or later. The data_o value is read from the array in RESP, not at capture.
- Reset mid-operation: the FSM returns to IDLE and the pending fill is discarded. data_valid_o is not asserted and memory is cleared.
- bus_msg_i and bus_addr_i are don't-care when bus_valid_i=0.

Test Plan:
1. Latency check. Reset, then BusRd at addr 0x0000_0030 (index 3), MEM_LATENCY=4.
   - busy_o is high for 4 cycles.
   - data_valid_o pulses exactly 4 cycles after the sample with data_o=0.
   - busy_o drops the next cycle.
2. Write-back then read. WriteBack addr 0x20 with flush_data_i=0xDEAD, then the next cycle BusRd addr 0x20.
   - Fill returns 0xDEAD after MEM_LATENCY.
   - An alias at addr 0x120 (16 lines) also returns 0xDEAD.
3. Cache-to-cache transfer. BusRdX addr 0x40 with flush_i=1 and data 0xCAFE.
   - No data_valid_o and busy_o stays 0.
   - A subsequent BusRd of 0x40 returns 0xCAFE.
4. Overrun. Issue a BusRd, then two cycles later BusRd with flush_i=1 to another index.
   - overrun_o rises and stays high.
   - The first fill completes on time.
   - The second index is unchanged (still 0).
5. Reset mid-operation. Assert rst_i during WAIT.
   - data_valid_o is never asserted and busy_o is 0 the cycle after reset.
   - Previously written lines read back 0.
6. Back-to-back reads with MEM_LATENCY=1 on indices 1, 2, 3, issued in each IDLE cycle.
   - Fills return in order, each one cycle after its sample.
   - Each read is sampled the cycle after the previous fill's RESP.
   - overrun_o stays 0.
